// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter and cycle sequencer for the read/write port of the 16x8 dual-port SRAM.
// Define SRAM_ARB_RR_EN for round-robin tie-break; otherwise requester A has fixed priority.
module sram_port_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_ack,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              ce_r,
  output logic              oe_r,
  output logic              rw_r,
  output logic [ADDR_W-1:0] address_r,
  inout  wire  [DATA_W-1:0] data_r,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, DONE = 2'd3} state_t;

  // Handshake: req is a level held until ack; a winner's we/addr/wdata are
  // captured at grant, gnt spans SETUP..DONE and ack is a one-cycle pulse in DONE.
  state_t              state_q, state_d;
  logic                owner_q, owner_d;     // 0 = A, 1 = B
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                drive_q, drive_d;
  logic                ce_d, oe_d, rw_d;
  logic                a_gnt_d, b_gnt_d, a_ack_d, b_ack_d, busy_d;
  logic                grant, pick_b;

`ifdef SRAM_ARB_RR_EN
  logic last_owner_q;
  // On a tie the requester that did not win last time goes first.
  assign pick_b = b_req & (~a_req | ~last_owner_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        last_owner_q <= 1'b1;
    else if (grant) last_owner_q <= pick_b;
  end
`else
  assign pick_b = b_req & ~a_req;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    grant   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (a_req | b_req) begin
          grant   = 1'b1;
          state_d = SETUP;
          owner_d = pick_b;
          we_d    = pick_b ? b_we    : a_we;
          addr_d  = pick_b ? b_addr  : a_addr;
          wdata_d = pick_b ? b_wdata : a_wdata;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP:   state_d = ACCESS;
      ACCESS:  state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Bus controls are decoded from the next state and registered so the SRAM
  // pins only ever change on a clock edge.
  always_comb begin
    ce_d    = 1'b1;
    oe_d    = 1'b0;
    rw_d    = 1'b1;
    drive_d = 1'b0;
    a_gnt_d = 1'b0;
    b_gnt_d = 1'b0;
    a_ack_d = 1'b0;
    b_ack_d = 1'b0;
    busy_d  = (state_d != IDLE);
    if (state_d != IDLE) begin
      a_gnt_d = ~owner_d;
      b_gnt_d = owner_d;
      drive_d = we_d;
    end
    case (state_d)
      SETUP:  ce_d = we_d;
      ACCESS: begin
        ce_d = 1'b0;
        oe_d = ~we_d;
        rw_d = ~we_d;
      end
      DONE: begin
        a_ack_d = ~owner_d;
        b_ack_d = owner_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      drive_q <= 1'b0;
      ce_r    <= 1'b1;
      oe_r    <= 1'b0;
      rw_r    <= 1'b1;
      a_gnt   <= 1'b0;
      b_gnt   <= 1'b0;
      a_ack   <= 1'b0;
      b_ack   <= 1'b0;
      busy    <= 1'b0;
      rdata   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      drive_q <= drive_d;
      ce_r    <= ce_d;
      oe_r    <= oe_d;
      rw_r    <= rw_d;
      a_gnt   <= a_gnt_d;
      b_gnt   <= b_gnt_d;
      a_ack   <= a_ack_d;
      b_ack   <= b_ack_d;
      busy    <= busy_d;
      if (state_q == ACCESS && !we_q) rdata <= data_r;
    end
  end

  assign address_r = addr_q;
  assign data_r    = drive_q ? wdata_q : {DATA_W{1'bz}};
  assign fsm_state = state_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural 16x8 SRAM on the shared port.
module tb_sram_port_arbiter;

`ifdef SRAM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       a_req, a_we, b_req, b_we;
  logic [3:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;
  logic       a_gnt, a_ack, b_gnt, b_ack, busy, ce_r, oe_r, rw_r;
  logic [7:0] rdata;
  logic [3:0] address_r;
  logic [1:0] fsm_state;
  wire  [7:0] data_r;

  logic [7:0] mem [16] = '{8'h00, 8'h11, 8'h03, 8'h33, 8'h44, 8'h50, 8'h66, 8'h77,
                           8'h88, 8'h99, 8'haa, 8'hbb, 8'hcc, 8'hdd, 8'hee, 8'h12};

  int tests = 0;
  int fails = 0;

  sram_port_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_gnt(a_gnt), .a_ack(a_ack),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_gnt(b_gnt), .b_ack(b_ack),
    .rdata(rdata), .busy(busy), .ce_r(ce_r), .oe_r(oe_r), .rw_r(rw_r),
    .address_r(address_r), .data_r(data_r), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  // SRAM model: drives the bus on an enabled read, captures on the edge ending a write strobe.
  // Undriven bus reads as 8'hFF through the pull-ups.
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (data_r[i]);
  end
  assign data_r = (!ce_r && rw_r && oe_r) ? mem[address_r] : 8'hzz;

  always @(posedge clk) begin
    if (!ce_r && !rw_r) mem[address_r] <= data_r;
  end

  // Continuous safety checks: exclusive grants, clean bus whenever the SRAM drives it.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      tests++;
      if (a_gnt && b_gnt) begin
        fails++;
        $display("FAIL mon_gnt_excl: a_gnt=%b b_gnt=%b exp not both 1 at %0t", a_gnt, b_gnt, $time);
      end
      tests++;
      if (oe_r && (data_r !== mem[address_r])) begin
        fails++;
        $display("FAIL mon_bus_contention: data_r=%h exp %h while oe_r=1 at %0t", data_r, mem[address_r], $time);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    a_req = 1'b0; b_req = 1'b0; a_we = 1'b0; b_we = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Driver: issue one access and wait (bounded) for its ack; lat = 0 means no ack arrived.
  task automatic run_access(input logic who, input logic we, input logic [3:0] addr,
                            input logic [7:0] wd, output int lat, output logic [7:0] rd);
    lat = 0;
    rd  = 8'h00;
    if (who) begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd; end
    else     begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd; end
    for (int i = 1; i <= 20; i++) begin
      tick();
      if ((!who && a_ack) || (who && b_ack)) begin
        lat = i;
        rd  = rdata;
        break;
      end
    end
    a_req = 1'b0;
    b_req = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    tests++; if (ce_r !== 1'b1) begin fails++; $display("FAIL rst_ce_r: got %b exp 1", ce_r); end
    tests++; if (oe_r !== 1'b0) begin fails++; $display("FAIL rst_oe_r: got %b exp 0", oe_r); end
    tests++; if (rw_r !== 1'b1) begin fails++; $display("FAIL rst_rw_r: got %b exp 1", rw_r); end
    tests++; if (address_r !== 4'h0) begin fails++; $display("FAIL rst_address_r: got %h exp 0", address_r); end
    tests++; if (data_r !== 8'hff) begin fails++; $display("FAIL rst_data_r_released: got %h exp ff", data_r); end
    tests++; if ({a_gnt, b_gnt, a_ack, b_ack} !== 4'b0000) begin
      fails++; $display("FAIL rst_gnt_ack: got %b exp 0000", {a_gnt, b_gnt, a_ack, b_ack}); end
    tests++; if (rdata !== 8'h00) begin fails++; $display("FAIL rst_rdata: got %h exp 00", rdata); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b exp 0", busy); end
    tests++; if (fsm_state !== 2'd0) begin fails++; $display("FAIL rst_state: got %0d exp 0", fsm_state); end
    rst = 1'b0;
    tick();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_no_req_busy: got %b exp 0", busy); end
  endtask

  task automatic test_read_basic;
    int ce_low = 0;
    int oe_high = 0;
    apply_reset();
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'd2;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (!ce_r) ce_low++;
      if (oe_r)  oe_high++;
      if (k == 1) begin
        tests++; if (fsm_state !== 2'd1) begin fails++; $display("FAIL rd_setup_state: got %0d exp 1", fsm_state); end
        tests++; if ({a_gnt, b_gnt, busy} !== 3'b101) begin fails++; $display("FAIL rd_setup_gnt: got %b exp 101", {a_gnt, b_gnt, busy}); end
        tests++; if ({ce_r, oe_r, rw_r} !== 3'b001) begin fails++; $display("FAIL rd_setup_ctl: got %b exp 001", {ce_r, oe_r, rw_r}); end
        tests++; if (address_r !== 4'd2) begin fails++; $display("FAIL rd_setup_addr: got %h exp 2", address_r); end
      end
      if (k == 2) begin
        tests++; if ({ce_r, oe_r, rw_r, a_ack} !== 4'b0110) begin fails++; $display("FAIL rd_access_ctl: got %b exp 0110", {ce_r, oe_r, rw_r, a_ack}); end
      end
      if (k == 3) begin
        tests++; if (a_ack !== 1'b1) begin fails++; $display("FAIL rd_ack_n3: got %b exp 1", a_ack); end
        tests++; if (rdata !== 8'h03) begin fails++; $display("FAIL rd_data: got %h exp 03", rdata); end
        tests++; if ({ce_r, oe_r} !== 2'b10) begin fails++; $display("FAIL rd_done_ctl: got %b exp 10", {ce_r, oe_r}); end
        a_req = 1'b0;
      end
      if (k == 4) begin
        tests++; if ({a_gnt, a_ack, busy} !== 3'b000) begin fails++; $display("FAIL rd_after_idle: got %b exp 000", {a_gnt, a_ack, busy}); end
        tests++; if (rdata !== 8'h03) begin fails++; $display("FAIL rd_data_held: got %h exp 03", rdata); end
      end
    end
    tests++; if (ce_low !== 2) begin fails++; $display("FAIL rd_ce_low_cycles: got %0d exp 2", ce_low); end
    tests++; if (oe_high !== 1) begin fails++; $display("FAIL rd_oe_high_cycles: got %0d exp 1", oe_high); end
  endtask

  task automatic test_write_then_read;
    int rw_low = 0;
    int lat;
    logic [7:0] rd;
    apply_reset();
    tests++; if (data_r !== 8'hff) begin fails++; $display("FAIL wr_idle_bus: got %h exp ff", data_r); end
    b_req = 1'b1; b_we = 1'b1; b_addr = 4'd9; b_wdata = 8'ha5;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (!rw_r) rw_low++;
      if (k == 1) begin
        tests++; if ({a_gnt, b_gnt} !== 2'b01) begin fails++; $display("FAIL wr_setup_gnt: got %b exp 01", {a_gnt, b_gnt}); end
        tests++; if ({ce_r, rw_r, oe_r} !== 3'b110) begin fails++; $display("FAIL wr_setup_ctl: got %b exp 110", {ce_r, rw_r, oe_r}); end
        tests++; if ({address_r, data_r} !== {4'd9, 8'ha5}) begin fails++; $display("FAIL wr_setup_bus: got %h/%h exp 9/a5", address_r, data_r); end
      end
      if (k == 2) begin
        tests++; if ({ce_r, rw_r, oe_r} !== 3'b000) begin fails++; $display("FAIL wr_access_ctl: got %b exp 000", {ce_r, rw_r, oe_r}); end
        tests++; if (data_r !== 8'ha5) begin fails++; $display("FAIL wr_access_data: got %h exp a5", data_r); end
      end
      if (k == 3) begin
        tests++; if ({b_ack, ce_r, rw_r} !== 3'b111) begin fails++; $display("FAIL wr_done: got %b exp 111", {b_ack, ce_r, rw_r}); end
        tests++; if (data_r !== 8'ha5) begin fails++; $display("FAIL wr_done_data: got %h exp a5", data_r); end
        b_req = 1'b0;
      end
      if (k == 4) begin
        tests++; if (data_r !== 8'hff) begin fails++; $display("FAIL wr_release: got %h exp ff", data_r); end
      end
    end
    tests++; if (rw_low !== 1) begin fails++; $display("FAIL wr_rw_low_cycles: got %0d exp 1", rw_low); end
    tests++; if (mem[9] !== 8'ha5) begin fails++; $display("FAIL wr_sram_content: got %h exp a5", mem[9]); end
    run_access(1'b0, 1'b0, 4'd9, 8'h00, lat, rd);
    tests++; if (lat !== 3) begin fails++; $display("FAIL rd9_latency: got %0d exp 3", lat); end
    tests++; if (rd !== 8'ha5) begin fails++; $display("FAIL rd9_data: got %h exp a5", rd); end
  endtask

  task automatic test_round_robin;
    int acks = 0;
    int j;
    logic own_b;
    apply_reset();
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'd2;
    b_req = 1'b1; b_we = 1'b0; b_addr = 4'd5;
    for (int k = 1; k <= 12; k++) begin
      tick();
      j = (k - 1) / 3;
      own_b = RR_EN && (j % 2 == 1);
      tests++; if ({a_gnt, b_gnt} !== {~own_b, own_b}) begin
        fails++; $display("FAIL rr_gnt_k%0d: got %b exp %b", k, {a_gnt, b_gnt}, {~own_b, own_b}); end
      tests++; if ({a_ack, b_ack} !== ((k % 3 == 0) ? {~own_b, own_b} : 2'b00)) begin
        fails++; $display("FAIL rr_ack_k%0d: got %b", k, {a_ack, b_ack}); end
      if (a_ack || b_ack) begin
        acks++;
        tests++; if (rdata !== (own_b ? 8'h50 : 8'h03)) begin fails++; $display("FAIL rr_rdata_k%0d: got %h", k, rdata); end
      end
    end
    tests++; if (acks !== 4) begin fails++; $display("FAIL rr_ack_count: got %0d exp 4", acks); end
    a_req = 1'b0;
    b_req = 1'b0;
    for (int i = 0; i < 10 && busy; i++) tick();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rr_drain_busy: got %b exp 0", busy); end
  endtask

  task automatic test_req_drop;
    apply_reset();
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'd5;
    tick();
    tests++; if (a_gnt !== 1'b1) begin fails++; $display("FAIL drop_gnt: got %b exp 1", a_gnt); end
    a_req = 1'b0;
    tick();
    tick();
    tests++; if (a_ack !== 1'b1) begin fails++; $display("FAIL drop_ack_n3: got %b exp 1", a_ack); end
    tests++; if (rdata !== 8'h50) begin fails++; $display("FAIL drop_rdata: got %h exp 50", rdata); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      tests++; if ({a_gnt, a_ack, busy} !== 3'b000) begin
        fails++; $display("FAIL drop_no_regrant_k%0d: got %b exp 000", k, {a_gnt, a_ack, busy}); end
    end
  endtask

  task automatic test_reset_mid_write;
    int lat;
    logic [7:0] rd;
    apply_reset();
    a_req = 1'b1; a_we = 1'b1; a_addr = 4'd4; a_wdata = 8'h77;
    tick();
    tick();
    tests++; if ({ce_r, rw_r} !== 2'b00) begin fails++; $display("FAIL rstw_access_ctl: got %b exp 00", {ce_r, rw_r}); end
    a_req = 1'b0;
    #2 rst = 1'b1;
    #1;
    tests++; if ({ce_r, rw_r, oe_r} !== 3'b110) begin fails++; $display("FAIL rstw_async_ctl: got %b exp 110", {ce_r, rw_r, oe_r}); end
    tests++; if ({a_gnt, a_ack, busy} !== 3'b000) begin fails++; $display("FAIL rstw_async_gnt: got %b exp 000", {a_gnt, a_ack, busy}); end
    tests++; if ({address_r, data_r} !== {4'h0, 8'hff}) begin fails++; $display("FAIL rstw_async_bus: got %h/%h exp 0/ff", address_r, data_r); end
    tick();
    rst = 1'b0;
    tick();
    tests++; if ({a_ack, busy} !== 2'b00) begin fails++; $display("FAIL rstw_no_ack: got %b exp 00", {a_ack, busy}); end
    run_access(1'b0, 1'b0, 4'd2, 8'h00, lat, rd);
    tests++; if (lat !== 3) begin fails++; $display("FAIL rstw_rd_latency: got %0d exp 3", lat); end
    tests++; if (rd !== 8'h03) begin fails++; $display("FAIL rstw_rd_data: got %h exp 03", rd); end
  endtask

  initial begin
    rst = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_addr = 4'd0; a_wdata = 8'h00;
    b_req = 1'b0; b_we = 1'b0; b_addr = 4'd0; b_wdata = 8'h00;
    test_reset();
    test_read_basic();
    test_write_then_read();
    test_round_robin();
    test_req_drop();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Synchronous controller that shares the read/write (right) port of the 16x8 dual-port SRAM between two requesters. Requester A is the CPU load/store unit; requester B is the program loader/DMA. It arbitrates pending requests and sequences the SRAM's active-low chip enable, read/write select, output enable and bidirectional data bus through a glitch-free setup/access/complete cycle. It returns read data and a one-cycle acknowledge to the winner. The SRAM's left (read-only) port is not touched by this block.

## Interface
Parameters:
- ADDR_W, 4, SRAM address width
- DATA_W, 8, SRAM data width

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- a_req  in  1  requester A access request, level
- a_we  in  1  A: 1 = write, 0 = read
- a_addr  in  ADDR_W  A address
- a_wdata  in  DATA_W  A write data
- a_gnt  out  1  A is the current owner (SETUP..DONE)
- a_ack  out  1  one-cycle pulse: A's access complete
- b_req, b_we, b_addr, b_wdata, b_gnt, b_ack  same as A, for requester B
- rdata  out  DATA_W  read result, valid in ack cycle, held until next read completes
- busy  out  1  FSM not in IDLE
- ce_r  out  1  SRAM chip enable, active low
- oe_r  out  1  SRAM output enable, active high
- rw_r  out  1  SRAM 1 = read, 0 = write
- address_r  out  ADDR_W  SRAM address
- data_r  inout  DATA_W  SRAM data bus; driven only while writing, else Z

## Operation
- FSM states: IDLE, SETUP, ACCESS, DONE.
- Arbitration is evaluated in IDLE and DONE. With no request, the FSM goes to or stays in IDLE. With a request, the winner's we/addr/wdata are latched, its gnt is set, and the FSM goes to SETUP.
- Read sequence:
  - SETUP: address_r = addr, rw_r = 1, ce_r = 0, oe_r = 0.
  - ACCESS: oe_r = 1; data_r is sampled into rdata at the end of ACCESS.
  - DONE: ce_r = 1, oe_r = 0, ack = 1.
- Write sequence:
  - SETUP: address_r and data_r driven, rw_r = 1, ce_r = 1.
  - ACCESS: ce_r = 0, rw_r = 0.
  - DONE: rw_r = 1, ce_r = 1, data_r still driven, ack = 1.
  - data_r is released in the following cycle unless the next access is also a write.
- address_r and the write data are stable for the whole SETUP..DONE window. rw_r never goes low while address_r is changing.
- Requests are latched at grant. Deasserting req after grant does not abort the access; ack still fires.
- A requester holds req until it sees ack. A requester that holds req through ack is treated as a new request in DONE.
- oe_r is never 1 while the bus is driven (no contention).
- Round-robin (see Configuration): a one-bit last_owner pointer. On a tie, the requester that is not last_owner wins. A single requester always wins. After reset, last_owner = B, so A wins the first tie.

## Timing
- Read or write request seen high at edge N (FSM in IDLE): SETUP at N+1, ACCESS at N+2, DONE/ack at N+3.
- Read data valid on rdata from the ack cycle onward.
- Back-to-back accesses: DONE goes directly to SETUP, giving 3 cycles per access and 100% port utilisation with 2 active requesters.
- gnt is high from SETUP through DONE. a_gnt and b_gnt are never both high.
- Reset values, asserted asynchronously:
  - State IDLE.
  - ce_r = 1, oe_r = 0, rw_r = 1.
  - address_r = 0, data_r = Z.
  - a_gnt = b_gnt = a_ack = b_ack = 0.
  - rdata = 0, busy = 0, last_owner = B.
- Reset mid-access: outputs return to reset values immediately and no ack is issued. SRAM contents at an in-flight write address are undefined.

## Configuration
- SRAM_ARB_RR_EN defined: round-robin tie-break as above.
- SRAM_ARB_RR_EN undefined: fixed priority; A always wins a tie and the last_owner flop is omitted. B can starve under continuous A traffic, which is accepted for the loader-only-at-boot use.

## Test plan
- After reset, check every output against its reset value. A reads address 2 (preloaded 8'h03): ack at N+3 and rdata = 8'h03; ce_r is low for exactly 2 cycles and oe_r for 1.
- B writes 8'hA5 to address 9, then A reads address 9: rdata = 8'hA5. rw_r is low only in ACCESS, and data_r is Z outside the write window.
- A and B both request continuously, with RR enabled: grants alternate A, B, A, B, with one ack every 3 cycles. With the macro undefined, A is granted every time.
- A deasserts req in the SETUP cycle: the access still completes with a_ack at N+3, and there is no second grant.
- rst is asserted during ACCESS of a write: ce_r = 1 and rw_r = 1 asynchronously, and no ack. A subsequent read of another address returns correct data.
- Throughout every scenario, check that oe_r and data_r are never driven in the same cycle and that a_gnt and b_gnt are never both high.
